// File: rtl/riscv_imm_pkg.sv
// Purpose: shared types, format/opcode codes and the immediate decode function
//          for the pipelined RISC-V immediate generator.
// Contents: imm_fmt_e format codes, SRC_AUTO select, opcode constants,
//           imm_dec_t decode result, skid_state_e, imm_decode().
package riscv_imm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FMT_W   = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } imm_fmt_e;

    // imm_src value asking for the format to be taken from the opcode
    localparam logic [FMT_W-1:0] SRC_AUTO = 3'd7;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef struct packed {
        imm_fmt_e           fmt;
        logic               illegal;
        logic [INSTR_W-1:0] imm;
    } imm_dec_t;

    // Occupancy of the two-entry output stage
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_MAIN  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Resolve the format and assemble the 32-bit sign-extended raw immediate
    function automatic imm_dec_t imm_decode(input logic [INSTR_W-1:0] instr,
                                            input logic [FMT_W-1:0]   imm_src);
        imm_dec_t d;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b0;
        d.imm     = '0;
        case (imm_src)
            3'd0: d.fmt = FMT_I;
            3'd1: d.fmt = FMT_S;
            3'd2: d.fmt = FMT_B;
            3'd3: d.fmt = FMT_U;
            3'd4: d.fmt = FMT_J;
            SRC_AUTO: begin
                case (instr[6:0])
                    OPC_LOAD, OPC_OP_IMM, OPC_JALR,
                    OPC_SYSTEM, OPC_MISC_MEM: d.fmt = FMT_I;
                    OPC_STORE:                d.fmt = FMT_S;
                    OPC_BRANCH:               d.fmt = FMT_B;
                    OPC_LUI, OPC_AUIPC:       d.fmt = FMT_U;
                    OPC_JAL:                  d.fmt = FMT_J;
                    OPC_OP:                   d.fmt = FMT_NONE;
                    default:                  d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        case (d.fmt)
            FMT_I: d.imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: d.imm = {instr[31:12], 12'b0};
            FMT_J: d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: d.imm = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Purpose: valid/ready bus of the immediate generator.
// Signals: in_valid/in_ready/instr/imm_src (request side),
//          out_valid/out_ready/imm_out/fmt_out/illegal_out (result side).
// Modports: master drives requests and consumes results; slave is the generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_out;
    logic [2:0]      fmt_out;
    logic            illegal_out;

    modport master (
        output in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm_out, fmt_out, illegal_out
    );

    modport slave (
        input  in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm_out, fmt_out, illegal_out
    );
endinterface

// File: rtl/imm_skid_buf.sv
// Purpose: generic two-entry valid/ready output stage (main + skid register).
// Ports: clk, reset (async, active-high); i_in_valid/o_in_ready/i_in_data input
//        side; o_out_valid/i_out_ready/o_out_data output side. All outputs come
//        straight from flops; o_in_ready never depends on i_out_ready.
module imm_skid_buf
    import riscv_imm_pkg::*;
#(
    parameter int unsigned  W       = 36,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data
);

    skid_state_e r_state;
    skid_state_e w_state_next;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main;
    logic w_load_skid;
    logic w_skid_to_main;

    assign w_in_fire  = i_in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & i_out_ready;

    // State register; handshake flags are precomputed from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != SKID_FULL);
            r_out_valid <= (w_state_next != SKID_EMPTY);
        end
    end

    // Next-state and register-load decode
    always_comb begin
        w_state_next   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main  = 1'b1;
                    w_state_next = SKID_MAIN;
                end
            end
            SKID_MAIN: begin
                if (w_out_fire) begin
                    // Draining main frees it for a same-cycle reload
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                    end else begin
                        w_state_next = SKID_EMPTY;
                    end
                end else if (w_in_fire) begin
                    w_load_skid  = 1'b1;
                    w_state_next = SKID_FULL;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so no new input can arrive
                if (w_out_fire) begin
                    w_skid_to_main = 1'b1;
                    w_state_next   = SKID_MAIN;
                end
            end
            default: w_state_next = SKID_EMPTY;
        endcase
    end

    // Payload registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= RST_VAL;
            r_skid <= RST_VAL;
        end else begin
            if (w_load_main) begin
                r_main <= i_in_data;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_in_data;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_main;

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: pipelined RISC-V immediate generator (I/S/B/U/J, explicit or AUTO
//          select) with XLEN sign extension and a registered skid output stage.
// Ports: clk, reset (async, active-high), bus (imm_gen_pipe_if.slave).
module imm_gen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    imm_gen_pipe_if.slave  bus
);

    localparam int unsigned PAYLOAD_W = XLEN + FMT_W + 1;
    localparam logic [PAYLOAD_W-1:0] PAYLOAD_RST = {FMT_NONE, 1'b0, XLEN'(0)};

    imm_dec_t              w_dec;
    logic [XLEN-1:0]       w_imm_ext;
    logic [PAYLOAD_W-1:0]  w_payload_in;
    logic [PAYLOAD_W-1:0]  w_payload_out;

    assign w_dec = imm_decode(bus.instr, bus.imm_src);

    // Bit 31 of the raw immediate is always its sign, so a signed cast extends it
    assign w_imm_ext    = XLEN'($signed(w_dec.imm));
    assign w_payload_in = {w_dec.fmt, w_dec.illegal, w_imm_ext};

    imm_skid_buf #(
        .W       (PAYLOAD_W),
        .RST_VAL (PAYLOAD_RST)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (bus.in_valid),
        .o_in_ready  (bus.in_ready),
        .i_in_data   (w_payload_in),
        .o_out_valid (bus.out_valid),
        .i_out_ready (bus.out_ready),
        .o_out_data  (w_payload_out)
    );

    assign bus.fmt_out     = w_payload_out[PAYLOAD_W-1 -: FMT_W];
    assign bus.illegal_out = w_payload_out[XLEN];
    assign bus.imm_out     = w_payload_out[XLEN-1:0];

endmodule
